// File: rtl/frame_streamer_if.sv
// frame_streamer_if: AXI-Stream beat channel from the frame streamer to the FFT core.
interface frame_streamer_if #(parameter int W = 32);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer: reads one circular frame from BRAM starting at the captured head, optionally
// windows each sample, and streams it to the FFT core through a credit-limited output FIFO.
module frame_streamer #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 24,
    parameter int RD_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   head,
    input  logic                win_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]   coeff_idx,
    input  logic [COEFF_W-1:0]  coeff,
    frame_streamer_if.master    frame,
    input  logic                last_missing,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                dropped_start
);
    localparam int D  = RD_LAT + 2;
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);
    localparam int MW = DATA_W + COEFF_W + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q, beat_q, rd_addr_q, coeff_idx_q;
    logic [ADDR_W:0]     k_q;
    logic                win_q, busy_q, done_q, aborted_q, dropped_q;
    logic [RD_LAT:0]     v_q;
    logic [DATA_W-1:0]   mem_q [D];
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;

    logic                pop, push, last_hs, abort, issue;
    logic signed [DATA_W-1:0] s;
    logic signed [MW-1:0]     prod;
    logic [DATA_W-1:0]        real_v;
    int                       inflight;

    always_comb begin
        inflight = 0;
        for (int i = 0; i <= RD_LAT; i++) inflight += int'(v_q[i]);
    end

    // v_q[RD_LAT] marks the cycle in which the returning sample and coefficient are on the inputs
    assign s       = $signed({~rd_data[DATA_W-1], rd_data[DATA_W-2:0]});
    assign prod    = MW'(s) * MW'($signed({1'b0, coeff}));
    assign real_v  = win_q ? DATA_W'(prod >>> COEFF_W) : s;
    assign push    = v_q[RD_LAT];
    assign pop     = frame.tvalid && frame.tready;
    assign last_hs = pop && beat_q == '1;
    assign abort   = state_q == STREAM && last_missing && !last_hs;
    // Counting this cycle's pop as freed space keeps one fetch per cycle with a FIFO of RD_LAT+2
    assign issue   = state_q == STREAM && !k_q[ADDR_W] && int'(cnt_q) + inflight - int'(pop) < D;

    assign frame.tvalid = cnt_q != '0;
    assign frame.tdata  = {{DATA_W{1'b0}}, mem_q[rd_q]};
    assign frame.tlast  = frame.tvalid && beat_q == '1;
    assign rd_addr       = rd_addr_q;
    assign coeff_idx     = coeff_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign dropped_start = dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            beat_q      <= '0;
            rd_addr_q   <= '0;
            coeff_idx_q <= '0;
            k_q         <= '0;
            win_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            dropped_q   <= 1'b0;
            v_q         <= '0;
            mem_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            dropped_q <= start && state_q == STREAM;
            if (state_q == IDLE) begin
                if (start) begin
                    base_q  <= head;
                    win_q   <= win_en;
                    k_q     <= '0;
                    beat_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= STREAM;
                end
            end else if (abort) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
                v_q       <= '0;
                cnt_q     <= '0;
                wr_q      <= '0;
                rd_q      <= '0;
            end else begin
                v_q <= {v_q[RD_LAT-1:0], issue};
                if (issue) begin
                    rd_addr_q   <= base_q + k_q[ADDR_W-1:0];
                    coeff_idx_q <= k_q[ADDR_W-1:0];
                    k_q         <= k_q + (ADDR_W + 1)'(1);
                end
                if (push) begin
                    mem_q[wr_q] <= real_v;
                    wr_q        <= wr_q == PW'(D - 1) ? '0 : wr_q + PW'(1);
                end
                if (pop) begin
                    rd_q   <= rd_q == PW'(D - 1) ? '0 : rd_q + PW'(1);
                    beat_q <= beat_q + ADDR_W'(1);
                end
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
                if (last_hs) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: randomized frames scored against a queue-based reference of the frame rules.
module tb_frame_streamer;
    localparam int AW = 4, DW = 16, CWID = 24, L = 2, N = 1 << AW;

    logic clk = 0, rst_n = 0, start = 0, win_en = 0, last_missing = 0;
    logic [AW-1:0] head = 0, rd_addr, coeff_idx;
    logic [DW-1:0] rd_data;
    logic [CWID-1:0] coeff;
    logic busy, done, aborted, dropped_start;

    frame_streamer_if #(.W(2 * DW)) fif ();

    frame_streamer #(.ADDR_W(AW), .DATA_W(DW), .COEFF_W(CWID), .RD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .head(head), .win_en(win_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .coeff_idx(coeff_idx), .coeff(coeff),
        .frame(fif), .last_missing(last_missing), .busy(busy), .done(done),
        .aborted(aborted), .dropped_start(dropped_start)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bram [N];
    logic [CWID-1:0] rom [N];
    logic [AW-1:0] ap [L];
    logic [AW-1:0] cp [L];

    always @(posedge clk) begin
        ap[0] <= rd_addr;
        cp[0] <= coeff_idx;
        for (int i = 1; i < L; i++) begin
            ap[i] <= ap[i-1];
            cp[i] <= cp[i-1];
        end
    end
    assign rd_data = bram[ap[L-1]];
    assign coeff   = rom[cp[L-1]];

    int total = 0, bad = 0, hs_cnt = 0, drop_cnt = 0;
    bit rnd_ready = 0;
    logic [32:0] q [$];
    logic prev_stall = 0;
    logic [32:0] prev_b = 0;
    logic [32:0] exp_b;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall && !aborted)
                chk("hold", {fif.tvalid, fif.tlast, fif.tdata}, {1'b1, prev_b});
            if (dropped_start) drop_cnt++;
            if (fif.tvalid && fif.tready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat actual=%0h required=none", {fif.tlast, fif.tdata});
                end else begin
                    exp_b = q.pop_front();
                    chk("beat", {fif.tlast, fif.tdata}, exp_b);
                end
            end
            prev_stall = fif.tvalid && !fif.tready;
            prev_b = {fif.tlast, fif.tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fif.tready = rnd_ready ? 1'($urandom) : 1'b1;
    endtask

    // Expected beat k: sample at (head+k) mod N made signed, optionally scaled by rom[k]/2^CWID, floored
    task automatic push_frame(int h, bit w);
        int a;
        longint sv, r;
        logic [DW-1:0] rv;
        for (int k = 0; k < N; k++) begin
            a = (h + k) % N;
            sv = longint'(bram[a]) - 32768;
            r = w ? (sv * longint'(rom[k])) >>> CWID : sv;
            rv = r[DW-1:0];
            q.push_back({k == N - 1, 16'h0, rv});
        end
    endtask

    task automatic launch(int h, bit w);
        push_frame(h, w);
        hs_cnt = 0;
        head = AW'(h);
        win_en = w;
        start = 1;
        tick();
        start = 0;
        head = AW'($urandom);
        win_en = 1'($urandom);
    endtask

    task automatic wait_done(string nm, bit timing);
        int cf, cd;
        cf = -1;
        cd = 0;
        while (!done && cd < 300) begin
            tick();
            cd++;
            if (cf < 0 && fif.tvalid) cf = cd;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=%0d cycles required=done", nm, cd);
        end
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_beats"}, hs_cnt, N);
        chk({nm, "_left"}, q.size(), 0);
        if (timing) begin
            chk({nm, "_first_lat_ok"}, cf <= L + 2 && cf > 0, 1);
            chk({nm, "_done_lat_ok"}, cd <= N + L + 2, 1);
        end
        tick();
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=stuck required=finish");
        $fatal(1);
    end

    initial begin
        int c;
        fif.tready = 1;
        for (int i = 0; i < N; i++) begin
            bram[i] = 0;
            rom[i] = 0;
        end
        repeat (3) tick();
        chk("rst_out", {fif.tvalid, fif.tlast, fif.tdata, rd_addr, coeff_idx, busy, done, aborted, dropped_start}, 0);
        rst_n = 1;
        tick();

        // plain frame across the wrap point
        for (int i = 0; i < N; i++) bram[i] = DW'(i * 16'h1000);
        launch(14, 0);
        wait_done("f1", 1);

        // random data, coefficients and back-pressure
        rnd_ready = 1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                bram[i] = DW'($urandom);
                rom[i] = CWID'($urandom);
            end
            launch(int'($urandom_range(0, N - 1)), 1'(f));
            wait_done("rnd", 0);
        end
        rnd_ready = 0;

        // half-scale window then zero window
        for (int i = 0; i < N; i++) begin
            bram[i] = DW'($urandom);
            rom[i] = 24'h800000;
        end
        bram[5] = 16'hC000;
        bram[6] = 16'h0000;
        launch(5, 1);
        wait_done("win_half", 1);
        for (int i = 0; i < N; i++) rom[i] = 0;
        launch(int'($urandom_range(0, N - 1)), 1);
        wait_done("win_zero", 1);

        // abort after five beats
        for (int i = 0; i < N; i++) bram[i] = DW'($urandom);
        launch(int'($urandom_range(0, N - 1)), 0);
        c = 0;
        while (hs_cnt < 5 && c < 100) begin tick(); c++; end
        chk("abort_reach5", hs_cnt >= 5, 1);
        last_missing = 1;
        tick();
        last_missing = 0;
        chk("abort_out", {fif.tvalid, aborted, done, busy}, 4'b0100);
        q.delete();
        repeat (6) tick();
        chk("abort_quiet", {fif.tvalid, aborted, busy}, 0);
        last_missing = 1;
        tick();
        last_missing = 0;
        chk("idle_lm_ignored", {aborted, busy}, 0);
        launch(3, 0);
        wait_done("post_abort", 1);

        // restart attempts mid-frame and on the final handshake
        drop_cnt = 0;
        launch(int'($urandom_range(0, N - 1)), 0);
        c = 0;
        while (hs_cnt < 7 && c < 100) begin tick(); c++; end
        start = 1;
        head = 0;
        tick();
        start = 0;
        chk("drop1", dropped_start, 1);
        c = 0;
        while (!(fif.tvalid && fif.tlast) && c < 100) begin tick(); c++; end
        start = 1;
        tick();
        start = 0;
        chk("drop2_done", {done, dropped_start, busy}, 3'b110);
        repeat (4) tick();
        chk("drop_no_frame", {busy, fif.tvalid}, 0);
        chk("drop_cnt", drop_cnt, 2);
        chk("drop_left", q.size(), 0);

        // asynchronous reset mid-frame
        for (int i = 0; i < N; i++) rom[i] = CWID'($urandom);
        launch(int'($urandom_range(0, N - 1)), 1);
        c = 0;
        while (hs_cnt < 9 && c < 100) begin tick(); c++; end
        rst_n = 0;
        #1;
        chk("rst_mid", {fif.tvalid, fif.tlast, fif.tdata, rd_addr, coeff_idx, busy, done, aborted, dropped_start}, 0);
        q.delete();
        repeat (2) tick();
        rst_n = 1;
        tick();
        launch(int'($urandom_range(0, N - 1)), 0);
        wait_done("post_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
